ysyx_22050612_div_seq: RTL

Multi-cycle divide sequencer for the RV64M divide/remainder group (divu, remu, divw, remw, plus div/rem/divuw/remuw for completeness) dispatched by the decode stage. Runs a radix-2 restoring divider, one quotient bit per cycle, under an IDLE/BUSY/DONE state machine. Uses valid/ready handshakes on both sides so the execute stage can stall while the divider is occupied. Handles RISC-V divide-by-zero and signed-overflow results without iterating.

---
 rtl/ysyx_22050612_div_seq_if.sv | 24 ++
 rtl/ysyx_22050612_div_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/ysyx_22050612_div_seq_if.sv
// Handshake bundle between the decode/execute side and the divide sequencer.
// The master issues operands and consumes results; the slave is the divider.
interface ysyx_22050612_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        is_signed;
    logic        is_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    modport master (
        output in_valid, dividend, divisor, is_signed, is_word, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, is_word, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22050612_div_seq.sv
// Radix-2 restoring divide sequencer for the RV64M div/rem group.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module ysyx_22050612_div_seq (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    ysyx_22050612_div_seq_if.slave      io
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [63:0] a_ext, b_ext, mag_a, mag_b;
    logic        div_zero, overflow, accept;
    logic [63:0] rem, quo, dvs;
    logic [6:0]  cnt;
    logic        sign_q, sign_r, word;
    logic [63:0] q_out, r_out;

    logic [64:0] rem_sh, diff;
    logic        borrow;
    logic [63:0] rem_nx, quo_nx;
    logic [63:0] q_fin, r_fin, q_sgn, r_sgn, q_res, r_res;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    always_comb begin
        if (io.is_word) begin
            a_ext = io.is_signed ? sext32(io.dividend[31:0]) : {32'h0, io.dividend[31:0]};
            b_ext = io.is_signed ? sext32(io.divisor[31:0])  : {32'h0, io.divisor[31:0]};
        end else begin
            a_ext = io.dividend;
            b_ext = io.divisor;
        end
        div_zero = (b_ext == '0);
        overflow = io.is_signed && (b_ext == '1) &&
                   (a_ext == (io.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        mag_a = (io.is_signed && a_ext[63]) ? (64'd0 - a_ext) : a_ext;
        mag_b = (io.is_signed && b_ext[63]) ? (64'd0 - b_ext) : b_ext;
    end

    assign accept = (state == IDLE) && io.in_valid && !flush;

    // Word ops park the 32-bit dividend in quo[63:32] so both widths shift identically.
    always_comb begin
        rem_sh = {rem, quo[63]};
        diff   = rem_sh - {1'b0, dvs};
        borrow = (rem_sh < {1'b0, dvs});
        rem_nx = borrow ? rem_sh[63:0] : diff[63:0];
        quo_nx = {quo[62:0], ~borrow};
        q_fin  = word ? {32'h0, quo_nx[31:0]} : quo_nx;
        r_fin  = word ? {32'h0, rem_nx[31:0]} : rem_nx;
        q_sgn  = sign_q ? (64'd0 - q_fin) : q_fin;
        r_sgn  = sign_r ? (64'd0 - r_fin) : r_fin;
        q_res  = word ? sext32(q_sgn[31:0]) : q_sgn;
        r_res  = word ? sext32(r_sgn[31:0]) : r_sgn;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (div_zero || overflow) ? DONE : BUSY;
            BUSY: if (cnt == 7'd1) state_next = DONE;
            DONE: if (io.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            word   <= 1'b0;
            q_out  <= '0;
            r_out  <= '0;
        end else if (accept) begin
            word   <= io.is_word;
            sign_q <= io.is_signed && (a_ext[63] ^ b_ext[63]);
            sign_r <= io.is_signed && a_ext[63];
            rem    <= '0;
            dvs    <= io.is_word ? {32'h0, mag_b[31:0]} : mag_b;
            quo    <= io.is_word ? {mag_a[31:0], 32'h0} : mag_a;
            cnt    <= io.is_word ? 7'd32 : 7'd64;
            if (div_zero) begin
                q_out <= '1;
                r_out <= io.is_word ? sext32(a_ext[31:0]) : a_ext;
            end else if (overflow) begin
                q_out <= a_ext;
                r_out <= '0;
            end
        end else if (state == BUSY && !flush) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
                q_out <= q_res;
                r_out <= r_res;
            end
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.quotient  = q_out;
    assign io.remainder = r_out;
endmodule
